// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the stream_fifo block.
package stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_FIFO_DEPTH    = 256;
  localparam int DEF_FIFO_SKID     = 32;
  localparam int DEF_AFULL_THRESH  = 192;
  localparam int DEF_AEMPTY_THRESH = 4;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Storage array for stream_fifo: one synchronous write port, one asynchronous read port.
module stream_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clkIn) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with skid region and occupancy flags.
// Define STREAM_FIFO_ERR_EN to add the sticky overflowOut error output.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int FIFO_SKID     = DEF_FIFO_SKID,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter int COUNT_WIDTH   = countWidth(FIFO_DEPTH)
) (
  input  logic                   clkIn,
  input  logic                   rstNIn,
  input  logic                   flushIn,
  input  logic [DATA_WIDTH-1:0]  wrDataIn,
  input  logic                   wrValidIn,
  output logic                   wrReadyOut,
  output logic [DATA_WIDTH-1:0]  rdDataOut,
  output logic                   rdValidOut,
  input  logic                   rdReadyIn,
  output logic [COUNT_WIDTH-1:0] countOut,
  output logic                   almostFullOut,
`ifdef STREAM_FIFO_ERR_EN
  output logic                   overflowOut,
`endif
  output logic                   almostEmptyOut
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] READY_C  = COUNT_WIDTH'(FIFO_DEPTH - FIFO_SKID);
  localparam logic [COUNT_WIDTH-1:0] AFULL_C  = COUNT_WIDTH'(AFULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_C = COUNT_WIDTH'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("stream_fifo: FIFO_DEPTH must be a power of two >= 4");
  end
  if (FIFO_SKID < 1 || FIFO_SKID > FIFO_DEPTH - 2) begin : gBadSkid
    $error("stream_fifo: FIFO_SKID must lie in 1..FIFO_DEPTH-2");
  end
  if (AFULL_THRESH > FIFO_DEPTH || AEMPTY_THRESH > FIFO_DEPTH) begin : gBadThresh
    $error("stream_fifo: thresholds must not exceed FIFO_DEPTH");
  end
  if (DATA_WIDTH < 1) begin : gBadWidth
    $error("stream_fifo: DATA_WIDTH must be >= 1");
  end

  logic [PTR_WIDTH-1:0]   wrPtr;
  logic [PTR_WIDTH-1:0]   rdPtr;
  logic [COUNT_WIDTH-1:0] countNext;
  logic                   doWrite;
  logic                   doRead;

  // A read at full frees the slot the same-cycle write lands in.
  always_comb begin
    doRead  = rdValidOut & rdReadyIn & ~flushIn;
    doWrite = wrValidIn & ~flushIn & ((countOut != DEPTH_C) | doRead);
    if (flushIn) begin
      countNext = '0;
    end else if (doWrite & ~doRead) begin
      countNext = countOut + COUNT_WIDTH'(1);
    end else if (doRead & ~doWrite) begin
      countNext = countOut - COUNT_WIDTH'(1);
    end else begin
      countNext = countOut;
    end
  end

  // Pointers, occupancy and flags, all registered from the next count.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      countOut       <= '0;
      wrReadyOut     <= 1'b1;
      rdValidOut     <= 1'b0;
      almostFullOut  <= 1'b0;
      almostEmptyOut <= 1'b1;
    end else if (flushIn) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      countOut       <= '0;
      wrReadyOut     <= 1'b1;
      rdValidOut     <= 1'b0;
      almostFullOut  <= 1'b0;
      almostEmptyOut <= 1'b1;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + PTR_WIDTH'(1);
      end
      if (doRead) begin
        rdPtr <= rdPtr + PTR_WIDTH'(1);
      end
      countOut       <= countNext;
      wrReadyOut     <= (countNext < READY_C);
      rdValidOut     <= (countNext != '0);
      almostFullOut  <= (countNext >= AFULL_C);
      almostEmptyOut <= (countNext <= AEMPTY_C);
    end
  end

`ifdef STREAM_FIFO_ERR_EN
  logic dropWrite;
  assign dropWrite = wrValidIn & ~flushIn & (countOut == DEPTH_C) & ~doRead;

  // Sticky record of any word dropped at full.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      overflowOut <= 1'b0;
    end else if (flushIn) begin
      overflowOut <= 1'b0;
    end else if (dropWrite) begin
      overflowOut <= 1'b1;
    end else begin
      overflowOut <= overflowOut;
    end
  end
`endif

  stream_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(PTR_WIDTH)
  ) uRam (
    .clkIn (clkIn),
    .wrEn  (doWrite),
    .wrAddr(wrPtr),
    .wrData(wrDataIn),
    .rdAddr(rdPtr),
    .rdData(rdDataOut)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo at default parameters; honours STREAM_FIFO_ERR_EN.
module tb_stream_fifo;

  localparam int DW = 32;
  localparam int D  = 256;
  localparam int SKID = 32;
  localparam int AF = 192;
  localparam int AE = 4;

  logic          clkIn = 1'b0;
  logic          rstNIn = 1'b1;
  logic          flushIn = 1'b0;
  logic [DW-1:0] wrDataIn = '0;
  logic          wrValidIn = 1'b0;
  logic          rdReadyIn = 1'b0;
  logic          wrReadyOut;
  logic [DW-1:0] rdDataOut;
  logic          rdValidOut;
  logic [8:0]    countOut;
  logic          almostFullOut;
  logic          almostEmptyOut;
`ifdef STREAM_FIFO_ERR_EN
  logic          overflowOut;
  bit            mOvf = 1'b0;
`endif

  int nChecks = 0;
  int nFails  = 0;
  logic [DW-1:0] sbQ[$];
  int mCount = 0;

  stream_fifo dut (
    .clkIn         (clkIn),
    .rstNIn        (rstNIn),
    .flushIn       (flushIn),
    .wrDataIn      (wrDataIn),
    .wrValidIn     (wrValidIn),
    .wrReadyOut    (wrReadyOut),
    .rdDataOut     (rdDataOut),
    .rdValidOut    (rdValidOut),
    .rdReadyIn     (rdReadyIn),
    .countOut      (countOut),
    .almostFullOut (almostFullOut),
`ifdef STREAM_FIFO_ERR_EN
    .overflowOut   (overflowOut),
`endif
    .almostEmptyOut(almostEmptyOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every status output with what the model occupancy implies.
  task automatic checkOutputs();
    check("countOut", 64'(countOut), 64'(mCount));
    check("rdValidOut", 64'(rdValidOut), 64'(mCount != 0));
    check("wrReadyOut", 64'(wrReadyOut), 64'(mCount < D - SKID));
    check("almostFullOut", 64'(almostFullOut), 64'(mCount >= AF));
    check("almostEmptyOut", 64'(almostEmptyOut), 64'(mCount <= AE));
`ifdef STREAM_FIFO_ERR_EN
    check("overflowOut", 64'(overflowOut), 64'(mOvf));
`endif
  endtask

  // Drive one cycle of inputs and advance the reference model.
  task automatic apply(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    bit rd;
    bit wr;
    wrValidIn = wv;
    wrDataIn  = wd;
    rdReadyIn = rr;
    flushIn   = fl;
    if (fl) begin
      sbQ.delete();
      mCount = 0;
`ifdef STREAM_FIFO_ERR_EN
      mOvf = 1'b0;
`endif
    end else begin
      rd = (mCount > 0) && rr;
      wr = wv && ((mCount < D) || rd);
      if (wr) sbQ.push_back(wd);
`ifdef STREAM_FIFO_ERR_EN
      if (wv && !wr) mOvf = 1'b1;
`endif
      mCount = mCount + int'(wr) - int'(rd);
    end
  endtask

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    @(posedge clkIn);
    #1;
    checkOutputs();
    apply(wv, wd, rr, fl);
  endtask

  task automatic drain();
    int n;
    n = mCount;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: every accepted read must deliver the oldest outstanding word.
  always @(negedge clkIn) begin
    if (rstNIn && rdValidOut && rdReadyIn && !flushIn) begin
      if (sbQ.size() == 0) begin
        check("rdValidOut_with_empty_scoreboard", 64'(rdValidOut), 64'd0);
      end else begin
        check("rdDataOut", 64'(rdDataOut), 64'(sbQ.pop_front()));
      end
    end
  end

  initial begin
    int maxN;
    int pw;
    int pr;
    #2 rstNIn = 1'b0;
    #1 checkOutputs();
    repeat (3) @(posedge clkIn);
    #1 rstNIn = 1'b1;

    // Fill with 1..maxN then read everything back.
    for (int t = 0; t < 3; t++) begin
      maxN = (t == 0) ? D : int'($urandom_range(1, D));
      for (int i = 1; i <= maxN; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      drain();
    end

    // Skid region, full, and dropped 257th word.
    for (int i = 0; i < 260; i++) step(1'b1, DW'(32'h1000 + i), 1'b0, 1'b0);

    // Sustained write+read at full; pointers wrap several times.
    for (int i = 0; i < 1000; i++) step(1'b1, DW'(32'h5000 + i), 1'b1, 1'b0);
    drain();

    // Flush at count 100 with a concurrent write.
    for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic in phases of differing pressure.
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0: begin pw = 90; pr = 30; end
        1: begin pw = 30; pr = 90; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 100; pr = 100; end
      endcase
      step(($urandom_range(0, 99) < pw), DW'($urandom), ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 599) == 0));
    end
    drain();

    // Asynchronous reset while holding 50 words.
    for (int i = 0; i < 50; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clkIn);
    #2;
    rstNIn = 1'b0;
    wrValidIn = 1'b0;
    rdReadyIn = 1'b0;
    flushIn = 1'b0;
    sbQ.delete();
    mCount = 0;
`ifdef STREAM_FIFO_ERR_EN
    mOvf = 1'b0;
`endif
    #1 checkOutputs();
    @(posedge clkIn);
    #1 checkOutputs();
    rstNIn = 1'b1;
    apply(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    step(1'b1, 32'hA5A5_0002, 1'b0, 1'b0);
    step(1'b1, 32'hA5A5_0003, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();

    if (sbQ.size() != 0) check("scoreboard_empty_at_end", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 256, entry count (power of 2, >=4).
REQ-003 SHALL have parameter FIFO_SKID, default 32, entries accepted after wrReadyOut falls (1..FIFO_DEPTH-2).
REQ-004 SHALL have parameter AFULL_THRESH, default 192, almost-full level.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 4, almost-empty level.
REQ-006 SHALL have ports: clkIn in 1 clock; rstNIn in 1 reset, asynchronous, active-low; one clock, all logic on rising edge of clkIn.
REQ-007 SHALL have ports: flushIn in 1 sync discard-all; wrDataIn in DATA_WIDTH; wrValidIn in 1; wrReadyOut out 1.
REQ-008 SHALL have ports: rdDataOut out DATA_WIDTH; rdValidOut out 1; rdReadyIn in 1.
REQ-009 SHALL have ports: countOut out COUNT_WIDTH=$clog2(FIFO_DEPTH+1) occupancy; almostFullOut out 1; almostEmptyOut out 1.
REQ-010 SHALL have port overflowOut out 1 sticky error, present only with STREAM_FIFO_ERR_EN.

Function
REQ-011 Write SHALL occur when wrValidIn=1 and count<FIFO_DEPTH, independent of wrReadyOut (skid region).
REQ-012 wrValidIn=1 at count==FIFO_DEPTH SHALL drop the word; pointers and count unchanged.
REQ-013 Read SHALL occur when rdValidOut=1 and rdReadyIn=1; rdDataOut first-word-fall-through, valid whenever rdValidOut=1.
REQ-014 Word written in cycle N SHALL appear at rdDataOut with rdValidOut=1 in cycle N+1 (empty FIFO).
REQ-015 rdValidOut SHALL equal (count!=0); registered, no combinational path from wrValidIn.
REQ-016 wrReadyOut SHALL equal (count < FIFO_DEPTH-FIFO_SKID), registered from next count.
REQ-017 almostFullOut SHALL equal (count>=AFULL_THRESH); almostEmptyOut SHALL equal (count<=AEMPTY_THRESH); both registered.
REQ-018 Simultaneous write and read SHALL leave count unchanged; allowed at full (read frees slot same cycle) and data order preserved.
REQ-019 At empty, simultaneous wrValidIn and rdReadyIn SHALL write only (no read of invalid data).
REQ-020 Pointers SHALL be $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH with no bubble.
REQ-021 flushIn=1 SHALL in next cycle zero pointers and count, suppress any same-cycle write/read, set flags to reset values.
REQ-022 Output order SHALL be strict FIFO; data never duplicated or reordered.

Reset
REQ-023 rstNIn low SHALL asynchronously clear pointers, count; outputs: wrReadyOut=1, rdValidOut=0, countOut=0, almostFullOut=0, almostEmptyOut=1, overflowOut=0; rdDataOut don't-care.
REQ-024 Reset mid-operation SHALL discard all contents; storage array not reset.
REQ-025 Deassertion SHALL be synchronous-released externally; first write accepted in first cycle after release.

Configuration
REQ-026 Macro STREAM_FIFO_ERR_EN defined: overflowOut present, set on any dropped write (REQ-012), held until flushIn or reset.
REQ-027 Macro undefined: overflowOut and its logic absent; all other behaviour identical.

Structure
REQ-028 Package stream_fifo_pkg SHALL hold count-width function and default parameter constants.
REQ-029 Storage SHALL be sub-module stream_fifo_ram (1 write, 1 async-read port, DATA_WIDTH x FIFO_DEPTH); pointers/flags in stream_fifo.
REQ-030 Parameter checks (FIFO_SKID, thresholds <=FIFO_DEPTH) SHALL fail elaboration when violated.

Verification
REQ-031 Defaults; write 1..maxN (maxN 1..256) then read all -> data 1..maxN in order, rdValidOut drops after last.
REQ-032 Write 224 words -> wrReadyOut=0 from count 224; 32 further writes accepted, count 256; 257th dropped, overflowOut=1 (ERR_EN).
REQ-033 Full FIFO, write+read 1000 cycles -> countOut stays 256, data continuous, pointers wrap.
REQ-034 Count 100, flushIn pulse with wrValidIn=1 -> next cycle countOut=0, rdValidOut=0, overflowOut=0.
REQ-035 Count 50, rstNIn low mid-cycle -> outputs immediately at reset values; 3 writes after release read back correctly.
REQ-036 Threshold sweep: count 4 -> almostEmptyOut=1, count 5 -> 0; count 191 -> almostFullOut=0, 192 -> 1.
